difftest_commit_buf: RTL and testbench
======================================

# difftest_commit_buf

Parametrised commit recorder between the core's writeback stage and the difftest reporting logic. Accepts a bundle of up to `NCH` committed instructions per cycle, buffers bundles in a `DEPTH`-entry FIFO, and drains them in order under a ready/valid handshake. It detects the trap instruction, freezes intake after it, and maintains the cycle and retired-instruction counters the trap event reports.

## Interface
- `XLEN`, 64: data/PC width.
- `NCH`, 2: commit lanes per bundle (1..4).
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `clk` in 1: clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: bundle offered.
- `in_ready` out 1: bundle accepted this cycle if `in_valid`.
- `in_lane_valid` in NCH: per-lane commit valid.
- `in_pc` in NCH*XLEN; `in_inst` in NCH*32; `in_wen` in NCH; `in_wdest` in NCH*5; `in_wdata` in NCH*XLEN: per-lane payload, lane i at slice i.
- `in_a0` in XLEN: architectural x10 value at commit (trap code source).
- `out_valid` out 1: head entry present.
- `out_ready` in 1: consumer takes head.
- `out_lane_valid` out NCH; `out_pc` out NCH*XLEN; `out_inst` out NCH*32; `out_wen` out NCH; `out_wdest` out NCH*8 (zero-extended); `out_wdata` out NCH*XLEN.
- `trap_valid` out 1; `trap_code` out 8; `trap_pc` out XLEN.
- `cycle_cnt` out 64; `instr_cnt` out 64.
- `overflow` out 1: sticky, bundle offered while not ready.
- `level` out $clog2(DEPTH)+1: current occupancy.

## Operation
- Push = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
- `in_ready = !trap_seen && (level < DEPTH || out_ready)`; full FIFO with simultaneous pop accepts the push, level unchanged.
- Pushed bundle with all `in_lane_valid` zero: handshake completes, nothing stored.
- Trap detect: lowest lane i with `in_lane_valid[i]` and `in_inst[i][6:0] == 7'h6b`. Stored entry keeps lanes ≤ i, lanes > i cleared; entry tagged trap with `in_a0[7:0]` and `in_pc[i]`. `trap_seen` sets; `in_ready` stays 0 until reset.
- On pop of a trap-tagged entry: `trap_valid` sets (sticky), `trap_code`/`trap_pc` load from the tag.
- `instr_cnt += popcount(out_lane_valid)` on every pop.
- `cycle_cnt += 1` every cycle while `trap_valid` is 0; frozen once set (includes trap cycle's increment).
- `overflow` sets when `in_valid && !in_ready && !trap_seen`; cleared only by reset.
- Empty FIFO: all `out_*` payload and `out_lane_valid` drive 0.
- Pointers wrap modulo DEPTH; `level` is pointer difference with extra bit.

## Timing
- Reset (async assert, any cycle including mid-drain): pointers, `level`, all flags, both counters, `trap_*` → 0; `in_ready` → 1; `out_valid` → 0; FIFO contents become unreachable.
- Push-to-output latency 1 cycle: bundle pushed at edge N visible on `out_*` after N; no same-cycle fall-through.
- `out_*` stable while `out_valid && !out_ready`.
- `trap_valid` rises the edge of the trap-entry pop; `instr_cnt` includes that entry after the same edge.
- `in_ready` drops the cycle after a trap push.

## Structure
- `TRAP_OPCODE` (7'h6b) and the 8-bit difftest dest width go in `defines.v`.
- One sub-module `commit_fifo`: generic DEPTH×W storage with pointers, `level`, registered read-out, zero-masking when empty; parent handles lane packing, trap tagging, counters.
- Entry width = NCH*(1+XLEN+32+1+5+XLEN) + 1 + 8 + XLEN.

## Test plan
- Reset then 3 bundles, lane_valid 2'b11, `out_ready`=1 → each appears 1 cycle after push, `instr_cnt`=6, `level` returns to 0.
- Hold `out_ready`=0, push 5 bundles (DEPTH=4) → 4 accepted, 5th sees `in_ready`=0, `overflow`=1, `level`=4; then push+pop same cycle at full → accepted, `level` stays 4.
- Bundle lane0 inst 0x0000006b, lane1 valid, `in_a0`=0x2A, pc0=0x80000010 → stored lane_valid 2'b01; on pop `trap_valid`=1, `trap_code`=0x2A, `trap_pc`=0x80000010, `in_ready` stays 0, `cycle_cnt` frozen.
- Trap on lane1 with two older entries queued → `trap_valid` only after third pop; `instr_cnt` counts both lanes of trap bundle.
- Push all-zero lane_valid bundle → `in_ready` handshake, `level` unchanged, `out_*` all 0.
- Assert `rst_n`=0 asynchronously mid-cycle with `level`=3, `trap_seen`=1 → all outputs 0 immediately, `in_ready`=1 after release.

Source files
------------

// File: rtl/difftest_commit_buf_pkg.sv
// Shared constants and width helpers for the difftest commit buffer.
// The trap opcode and the difftest destination width are kept here so every file agrees on them.
package difftest_commit_buf_pkg;

  localparam logic [6:0] TRAP_OPCODE = 7'h6b;
  localparam int         DT_WDEST_W  = 8;
  localparam int         RF_WDEST_W  = 5;
  localparam int         TRAP_CODE_W = 8;

  function automatic int lane_width(input int xlen);
    return 1 + xlen + 32 + 1 + RF_WDEST_W + xlen;
  endfunction

  function automatic int entry_width(input int nch, input int xlen);
    return nch * lane_width(xlen) + 1 + TRAP_CODE_W + xlen;
  endfunction

endpackage

// File: rtl/difftest_commit_buf_commit_fifo.sv
// Generic DEPTH x W register FIFO with wrap-bit pointers.
// The read port shows the head entry and is forced to zero whenever the FIFO is empty.
module commit_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == (AW+1)'(DEPTH));
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage has no reset: after reset the pointers make old contents unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/difftest_commit_buf.sv
// Commit recorder between writeback and difftest: packs commit bundles, buffers them,
// detects the trap instruction and keeps the cycle / retired-instruction counters.
module difftest_commit_buf
  import difftest_commit_buf_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NCH   = 2,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NCH-1:0]              in_lane_valid,
  input  logic [NCH*XLEN-1:0]         in_pc,
  input  logic [NCH*32-1:0]           in_inst,
  input  logic [NCH-1:0]              in_wen,
  input  logic [NCH*RF_WDEST_W-1:0]   in_wdest,
  input  logic [NCH*XLEN-1:0]         in_wdata,
  input  logic [XLEN-1:0]             in_a0,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NCH-1:0]              out_lane_valid,
  output logic [NCH*XLEN-1:0]         out_pc,
  output logic [NCH*32-1:0]           out_inst,
  output logic [NCH-1:0]              out_wen,
  output logic [NCH*DT_WDEST_W-1:0]   out_wdest,
  output logic [NCH*XLEN-1:0]         out_wdata,
  output logic                        trap_valid,
  output logic [TRAP_CODE_W-1:0]      trap_code,
  output logic [XLEN-1:0]             trap_pc,
  output logic [63:0]                 cycle_cnt,
  output logic [63:0]                 instr_cnt,
  output logic                        overflow,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int LW  = lane_width(XLEN);
  localparam int EW  = entry_width(NCH, XLEN);
  localparam int TAG = NCH * LW;

  // Lane field offsets, LSB first: wdata, wdest, wen, inst, pc, lane valid.
  localparam int O_WDEST = XLEN;
  localparam int O_WEN   = XLEN + RF_WDEST_W;
  localparam int O_INST  = O_WEN + 1;
  localparam int O_PC    = O_INST + 32;
  localparam int O_VLD   = O_PC + XLEN;

  logic          trap_seen;
  logic          trap_hit;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          store;
  logic [EW-1:0] entry_in;
  logic [EW-1:0] entry_out;
  logic [63:0]   retire_n;

  assign in_ready  = !trap_seen && (!fifo_full || out_ready);
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Bundles with no valid lane complete the handshake but occupy no entry.
  assign store     = push && (|in_lane_valid);

  // Lanes above the first trap lane are dropped entirely, payload included.
  always_comb begin
    entry_in = '0;
    trap_hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!trap_hit) begin
        entry_in[i*LW +: XLEN]              = in_wdata[i*XLEN +: XLEN];
        entry_in[i*LW+O_WDEST +: RF_WDEST_W] = in_wdest[i*RF_WDEST_W +: RF_WDEST_W];
        entry_in[i*LW+O_WEN]                = in_wen[i];
        entry_in[i*LW+O_INST +: 32]         = in_inst[i*32 +: 32];
        entry_in[i*LW+O_PC +: XLEN]         = in_pc[i*XLEN +: XLEN];
        entry_in[i*LW+O_VLD]                = in_lane_valid[i];
        if (in_lane_valid[i] && (in_inst[i*32 +: 7] == TRAP_OPCODE)) begin
          trap_hit                              = 1'b1;
          entry_in[TAG +: XLEN]                 = in_pc[i*XLEN +: XLEN];
          entry_in[TAG+XLEN +: TRAP_CODE_W]     = in_a0[TRAP_CODE_W-1:0];
          entry_in[TAG+XLEN+TRAP_CODE_W]        = 1'b1;
        end
      end
    end
  end

  commit_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (store),
    .pop   (pop),
    .wdata (entry_in),
    .rdata (entry_out),
    .level (level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    assign out_wdata[g*XLEN +: XLEN]           = entry_out[g*LW +: XLEN];
    assign out_wdest[g*DT_WDEST_W +: DT_WDEST_W] =
      {{(DT_WDEST_W-RF_WDEST_W){1'b0}}, entry_out[g*LW+O_WDEST +: RF_WDEST_W]};
    assign out_wen[g]                          = entry_out[g*LW+O_WEN];
    assign out_inst[g*32 +: 32]                = entry_out[g*LW+O_INST +: 32];
    assign out_pc[g*XLEN +: XLEN]              = entry_out[g*LW+O_PC +: XLEN];
    assign out_lane_valid[g]                   = entry_out[g*LW+O_VLD];
  end

  always_comb begin
    retire_n = '0;
    for (int i = 0; i < NCH; i++) begin
      retire_n = retire_n + {63'd0, out_lane_valid[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_seen  <= 1'b0;
      trap_valid <= 1'b0;
      trap_code  <= '0;
      trap_pc    <= '0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push && trap_hit) trap_seen <= 1'b1;
      if (pop && entry_out[TAG+XLEN+TRAP_CODE_W]) begin
        trap_valid <= 1'b1;
        trap_code  <= entry_out[TAG+XLEN +: TRAP_CODE_W];
        trap_pc    <= entry_out[TAG +: XLEN];
      end
      if (pop) instr_cnt <= instr_cnt + retire_n;
      // The trap-pop cycle still counts; the counter freezes from the next cycle on.
      if (!trap_valid) cycle_cnt <= cycle_cnt + 64'd1;
      if (in_valid && !in_ready && !trap_seen) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_difftest_commit_buf.sv
// Directed self-checking bench for difftest_commit_buf (XLEN=64, NCH=2, DEPTH=4).
module tb_difftest_commit_buf;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_lane_valid;
  logic [127:0]  in_pc;
  logic [63:0]   in_inst;
  logic [1:0]    in_wen;
  logic [9:0]    in_wdest;
  logic [127:0]  in_wdata;
  logic [63:0]   in_a0;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_lane_valid;
  logic [127:0]  out_pc;
  logic [63:0]   out_inst;
  logic [1:0]    out_wen;
  logic [15:0]   out_wdest;
  logic [127:0]  out_wdata;
  logic          trap_valid;
  logic [7:0]    trap_code;
  logic [63:0]   trap_pc;
  logic [63:0]   cycle_cnt;
  logic [63:0]   instr_cnt;
  logic          overflow;
  logic [2:0]    level;

  int n_run  = 0;
  int n_fail = 0;
  int exp_cyc = 0;
  bit frozen = 1'b0;

  difftest_commit_buf #(.XLEN(64), .NCH(2), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_lane_valid  (in_lane_valid),
    .in_pc          (in_pc),
    .in_inst        (in_inst),
    .in_wen         (in_wen),
    .in_wdest       (in_wdest),
    .in_wdata       (in_wdata),
    .in_a0          (in_a0),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_lane_valid (out_lane_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_wen        (out_wen),
    .out_wdest      (out_wdest),
    .out_wdata      (out_wdata),
    .trap_valid     (trap_valid),
    .trap_code      (trap_code),
    .trap_pc        (trap_pc),
    .cycle_cnt      (cycle_cnt),
    .instr_cnt      (instr_cnt),
    .overflow       (overflow),
    .level          (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected cycle_cnt model: one increment per edge until the trap pop has been seen.
  task automatic tick();
    @(posedge clk);
    if (!frozen) exp_cyc++;
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] lv,
                       input logic [63:0] pc0, input logic [63:0] pc1,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic [63:0] a0);
    in_valid      = v;
    in_lane_valid = lv;
    in_pc         = {pc1, pc0};
    in_inst       = {i1, i0};
    in_wen        = 2'b11;
    in_wdest      = {5'd11, 5'd10};
    in_wdata      = {~pc1, ~pc0};
    in_a0         = a0;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_level",     level,      0);
    chk("rst_out_valid", out_valid,  0);
    chk("rst_out_pc",    out_pc,     0);
    chk("rst_lane_vld",  out_lane_valid, 0);
    chk("rst_cycle",     cycle_cnt,  0);
    chk("rst_instr",     instr_cnt,  0);
    chk("rst_trap",      trap_valid, 0);
    chk("rst_trap_code", trap_code,  0);
    chk("rst_overflow",  overflow,   0);
    #1;
    rst_n   = 1'b1;
    exp_cyc = 0;
    frozen  = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 64'h0, 64'h0, 32'h0, 32'h0, 64'h0);
    #2;
    chk("init_level",    level,     0);
    chk("init_out_vld",  out_valid, 0);
    chk("init_in_ready", in_ready,  1);
    chk("init_cycle",    cycle_cnt, 0);
    #10;
    rst_n = 1'b1;
    tick();
    chk("cycle_first", cycle_cnt, 1);

    // Streaming: three full bundles with the consumer always ready.
    out_ready = 1'b1;
    drive(1'b1, 2'b11, 64'h1000, 64'h1004, 32'h13, 32'h13, 64'h0);
    #1;
    chk("s_in_ready", in_ready, 1);
    chk("s_no_fallthru", out_valid, 0);
    tick();
    chk("s_a_pc",    out_pc,    {64'h1004, 64'h1000});
    chk("s_a_wdest", out_wdest, {8'd11, 8'd10});
    chk("s_a_wdata", out_wdata, {~64'h1004, ~64'h1000});
    chk("s_a_level", level, 1);
    drive(1'b1, 2'b11, 64'h1100, 64'h1104, 32'h13, 32'h13, 64'h0);
    tick();
    chk("s_b_pc",    out_pc, {64'h1104, 64'h1100});
    chk("s_b_instr", instr_cnt, 2);
    drive(1'b1, 2'b11, 64'h1200, 64'h1204, 32'h13, 32'h13, 64'h0);
    tick();
    chk("s_c_pc",    out_pc, {64'h1204, 64'h1200});
    chk("s_c_instr", instr_cnt, 4);
    in_valid = 1'b0;
    tick();
    chk("s_instr6",  instr_cnt, 6);
    chk("s_level0",  level, 0);
    chk("s_empty_pc", out_pc, 0);
    chk("s_cycle",   cycle_cnt, 64'(exp_cyc));

    // Fill to full with the consumer stalled, then overflow and push+pop at full.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'b11, 64'h2000 + 64'(k*16), 64'h2004 + 64'(k*16), 32'h13, 32'h13, 64'h0);
      tick();
    end
    chk("f_level4", level, 4);
    drive(1'b1, 2'b11, 64'h2040, 64'h2044, 32'h13, 32'h13, 64'h0);
    #1;
    chk("f_not_ready", in_ready, 0);
    chk("f_ovf_before", overflow, 0);
    tick();
    chk("f_overflow", overflow, 1);
    chk("f_level_hold", level, 4);
    chk("f_head_stable", out_pc, {64'h2004, 64'h2000});
    out_ready = 1'b1;
    #1;
    chk("f_ready_pop", in_ready, 1);
    tick();
    chk("f_level_pp", level, 4);
    chk("f_head_d1", out_pc, {64'h2014, 64'h2010});
    chk("f_instr8", instr_cnt, 8);
    in_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("f_drain_pc", out_pc, {64'h2004 + 64'(k*16), 64'h2000 + 64'(k*16)});
    end
    tick();
    chk("f_drained", level, 0);
    chk("f_instr16", instr_cnt, 16);

    // All-zero lane_valid bundle: handshake only, nothing stored.
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 64'h3000, 64'h3004, 32'h13, 32'h13, 64'h0);
    #1;
    chk("z_in_ready", in_ready, 1);
    tick();
    chk("z_level", level, 0);
    chk("z_out_valid", out_valid, 0);
    chk("z_lane_vld", out_lane_valid, 0);
    chk("z_out_pc", out_pc, 0);
    chk("z_out_inst", out_inst, 0);
    in_valid = 1'b0;

    // Trap queued behind two entries, then asynchronous reset mid-cycle.
    drive(1'b1, 2'b11, 64'h4000, 64'h4004, 32'h13, 32'h13, 64'h0);
    tick();
    drive(1'b1, 2'b11, 64'h4010, 64'h4014, 32'h13, 32'h13, 64'h0);
    tick();
    drive(1'b1, 2'b11, 64'h4020, 64'h4024, 32'h13, 32'h6b, 64'h77);
    tick();
    chk("r_level3", level, 3);
    chk("r_ready_drop", in_ready, 0);
    in_valid = 1'b0;
    async_reset();
    drive(1'b0, 2'b00, 64'h0, 64'h0, 32'h0, 32'h0, 64'h0);
    tick();
    chk("r_post_cycle", cycle_cnt, 64'(exp_cyc));

    // Trap on lane 1 with two older entries queued.
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 64'h3000, 64'h3004, 32'h13, 32'h13, 64'h0);
    tick();
    drive(1'b1, 2'b11, 64'h3010, 64'h3014, 32'h13, 32'h13, 64'h0);
    tick();
    drive(1'b1, 2'b11, 64'h3020, 64'h3024, 32'h13, 32'h6b, 64'h55);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t1_ready0", in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("t1_pop1_trap", trap_valid, 0);
    chk("t1_pop1_cnt", instr_cnt, 2);
    tick();
    chk("t1_pop2_trap", trap_valid, 0);
    chk("t1_head_lv", out_lane_valid, 2'b11);
    chk("t1_head_pc", out_pc, {64'h3024, 64'h3020});
    tick();
    frozen = 1'b1;
    chk("t1_trap", trap_valid, 1);
    chk("t1_code", trap_code, 8'h55);
    chk("t1_pc", trap_pc, 64'h3024);
    chk("t1_instr6", instr_cnt, 6);
    in_valid = 1'b1;
    tick();
    tick();
    chk("t1_frozen", cycle_cnt, 64'(exp_cyc));
    chk("t1_still_blocked", in_ready, 0);
    chk("t1_no_ovf", overflow, 0);
    in_valid = 1'b0;

    // Trap on lane 0: lane 1 is discarded from the stored entry.
    async_reset();
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 64'h8000_0010, 64'h8000_0014, 32'h0000_006b, 32'h13, 64'h1234_002A);
    tick();
    in_valid = 1'b0;
    chk("t0_lane_vld", out_lane_valid, 2'b01);
    chk("t0_lane1_pc", out_pc, {64'h0, 64'h8000_0010});
    chk("t0_level", level, 1);
    #1;
    chk("t0_ready0", in_ready, 0);
    out_ready = 1'b1;
    tick();
    frozen = 1'b1;
    chk("t0_trap", trap_valid, 1);
    chk("t0_code", trap_code, 8'h2A);
    chk("t0_pc", trap_pc, 64'h8000_0010);
    chk("t0_instr1", instr_cnt, 1);
    tick();
    tick();
    chk("t0_frozen", cycle_cnt, 64'(exp_cyc));
    chk("t0_level0", level, 0);
    chk("t0_ready_stays0", in_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
